// File: rtl/fp_to_int_conv.sv
// Multi-cycle IEEE-754 single to 32-bit signed integer converter with valid/ready handshakes.
// Define FP2INT_ROUND_EN for round-to-nearest-even; the default build truncates toward zero.
module fp_to_int_conv #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_float,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic        overflow,
  output logic        inexact,
  output logic        nan_flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      r_state;
  state_t      w_next;

  logic        r_sign;
  logic [31:0] r_mag;
  logic [4:0]  r_cnt;
  logic        r_dir_left;
  logic        r_sticky;
  logic [31:0] r_out_int;
  logic        r_overflow;
  logic        r_inexact;
  logic        r_nan;
`ifdef FP2INT_ROUND_EN
  logic        r_guard;
`endif

  logic        w_accept;
  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_frac;
  logic        w_is_nan;
  logic        w_is_minint;
  logic        w_is_sat;
  logic        w_is_small;
  logic        w_is_special;
  logic        w_dir_left;
  logic [4:0]  w_cnt_init;
  logic [4:0]  w_amt;
  logic [31:0] w_out_mask;
  logic [31:0] w_mag_shifted;
  logic        w_sticky_next;
  logic [31:0] w_mag_final;
  logic        w_inexact_final;
  logic [31:0] w_signed;
`ifdef FP2INT_ROUND_EN
  logic [31:0] w_guard_mask;
  logic        w_guard_next;
  logic        w_round_up;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_int   = r_out_int;
  assign overflow  = r_overflow;
  assign inexact   = r_inexact;
  assign nan_flag  = r_nan;

  assign w_accept = in_valid & in_ready;
  assign w_sign   = in_float[31];
  assign w_exp    = in_float[30:23];
  assign w_frac   = in_float[22:0];

  // -2^31 is the one value with e=158 that fits exactly, so it bypasses saturation
  assign w_is_nan     = (w_exp == 8'hFF) && (w_frac != 23'd0);
  assign w_is_minint  = w_sign && (w_exp == 8'd158) && (w_frac == 23'd0);
  assign w_is_sat     = (w_exp >= 8'd158);
`ifdef FP2INT_ROUND_EN
  assign w_is_small   = (w_exp < 8'd126);
`else
  assign w_is_small   = (w_exp < 8'd127);
`endif
  assign w_is_special = w_is_nan | w_is_sat | w_is_small;

  assign w_dir_left = (w_exp > 8'd150);
  assign w_cnt_init = w_dir_left ? 5'(w_exp - 8'd150) : 5'(8'd150 - w_exp);

  assign w_amt         = (r_cnt > STEP) ? STEP : r_cnt;
  assign w_out_mask    = (32'd1 << w_amt) - 32'd1;
  assign w_mag_shifted = r_dir_left ? (r_mag << w_amt) : (r_mag >> w_amt);

`ifdef FP2INT_ROUND_EN
  // The previous guard falls below the new guard position, so it joins sticky
  assign w_guard_mask    = 32'd1 << (w_amt - 5'd1);
  assign w_guard_next    = |(r_mag & w_guard_mask);
  assign w_sticky_next   = r_sticky | r_guard | (|(r_mag & w_out_mask & ~w_guard_mask));
  assign w_round_up      = r_guard & (r_sticky | r_mag[0]);
  assign w_mag_final     = r_mag + {31'd0, w_round_up};
  assign w_inexact_final = r_guard | r_sticky;
`else
  assign w_sticky_next   = r_sticky | (|(r_mag & w_out_mask));
  assign w_mag_final     = r_mag;
  assign w_inexact_final = r_sticky;
`endif

  assign w_signed = r_sign ? (32'd0 - w_mag_final) : w_mag_final;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_special)            w_next = DONE;
          else if (w_cnt_init == 5'd0) w_next = SIGN;
          else                         w_next = SHIFT;
        end
      end
      SHIFT: if (w_amt == r_cnt) w_next = SIGN;
      SIGN:  w_next = DONE;
      DONE:  if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Results and flags are cleared on every accept so nothing stale survives into DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sign     <= 1'b0;
      r_mag      <= 32'd0;
      r_cnt      <= 5'd0;
      r_dir_left <= 1'b0;
      r_sticky   <= 1'b0;
      r_out_int  <= 32'd0;
      r_overflow <= 1'b0;
      r_inexact  <= 1'b0;
      r_nan      <= 1'b0;
`ifdef FP2INT_ROUND_EN
      r_guard    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign     <= w_sign;
            r_mag      <= {8'd0, 1'b1, w_frac};
            r_cnt      <= w_cnt_init;
            r_dir_left <= w_dir_left;
            r_sticky   <= 1'b0;
            r_out_int  <= 32'd0;
            r_overflow <= 1'b0;
            r_inexact  <= 1'b0;
            r_nan      <= 1'b0;
`ifdef FP2INT_ROUND_EN
            r_guard    <= 1'b0;
`endif
            if (w_is_nan) begin
              r_nan <= 1'b1;
            end else if (w_is_minint) begin
              r_out_int <= 32'h8000_0000;
            end else if (w_is_sat) begin
              r_out_int  <= w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
              r_overflow <= 1'b1;
            end else if (w_is_small) begin
              r_inexact <= (w_exp != 8'd0) || (w_frac != 23'd0);
            end
          end
        end
        SHIFT: begin
          r_mag <= w_mag_shifted;
          r_cnt <= r_cnt - w_amt;
          if (!r_dir_left) begin
            r_sticky <= w_sticky_next;
`ifdef FP2INT_ROUND_EN
            r_guard  <= w_guard_next;
`endif
          end
        end
        SIGN: begin
          r_out_int <= w_signed;
          r_inexact <= w_inexact_final;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/fp_to_int_conv.md
Name: fp_to_int_conv

Overview:
- Multi-cycle converter from IEEE-754 single precision to 32-bit signed integer. It is the inverse-direction companion of the sequential float adder datapath.
- Unpacks the float fields, then de-normalizes the mantissa with an iterative shifter. The normalizer, by contrast, shifts toward the leading one.
- Applies the sign and returns the integer over a valid/ready handshake.
- Sits between the float result bus and integer consumers.

Parameters:
- SHIFT_STEP, 1, maximum bit positions shifted per SHIFT cycle. Legal values are 1, 2, 4 and 8.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_float is valid.
- in_ready  output  1  converter can accept an operand.
- in_float  input  32  IEEE-754 single: sign bit 31, exponent e bits 30:23, fraction f bits 22:0.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- out_int  output  32  two's-complement result.
- overflow  output  1  result saturated.
- inexact  output  1  nonzero bits were discarded.
- nan_flag  output  1  input was NaN.

Behaviour:
- Reset, applied while reset=0 and asynchronous:
  - state goes to IDLE.
  - out_valid, out_int, overflow, inexact and nan_flag are all 0.
  - Shift register, counter and sticky bit are cleared.
  - in_ready is a decode of state==IDLE, so it reads 1 both during and after reset.
  - Reset in any state aborts the operation in flight; no output is produced for it.
- States are IDLE, SHIFT, SIGN and DONE.
- Acceptance happens at an edge where in_valid and in_ready are both 1. On acceptance, classify the operand and load the registers:
  - NaN (e=255, f!=0): out_int=0, nan_flag=1. Go to DONE.
  - Infinity, or e>=158: saturate. s=0 gives 0x7FFFFFFF; s=1 gives 0x80000000. overflow=1. Go to DONE.
  - Exception to the saturate rule: s=1, e=158, f=0 gives 0x80000000 with overflow=0.
  - e<127 (zero and denormals included): out_int=0, inexact=(e!=0 or f!=0). Go to DONE.
  - Otherwise (127<=e<=157):
    - mag = {1,f}, zero-extended to 32 bits.
    - cnt = |e-150|.
    - dir = left if e>150, right if e<150.
    - sticky = 0.
    - Go to SHIFT if cnt!=0, else to SIGN.
- SHIFT, each cycle:
  - Shift mag by min(SHIFT_STEP, cnt) in direction dir.
  - On right shifts, OR every bit shifted out into sticky.
  - Decrement cnt by the same amount.
  - Go to SIGN when cnt reaches 0.
- SIGN, one cycle:
  - out_int = s ? -mag : mag, taken modulo 2^32.
  - inexact = sticky.
  - Go to DONE.
- DONE:
  - out_valid=1; out_int and all flags are held stable.
  - At an edge with out_ready=1, go to IDLE and drop out_valid.
  - While in DONE, in_ready=0. There is no accept in the same cycle as the output handshake.
- Latency, counted from the accept edge N:
  - Special cases: out_valid=1 after edge N.
  - Normal path: out_valid=1 after edge N+k+1, where k=ceil(cnt/SHIFT_STEP).
- Rounding is truncation toward zero.
- Maximum left shift is 7, so the normal path can never overflow.
- The flags are mutually exclusive, except that overflow=1 implies inexact=0.

Optional Feature:
- Macro: FP2INT_ROUND_EN.
- Defined:
  - Round to nearest, ties to even.
  - On right shifts, track the guard bit (last bit shifted out) in addition to sticky.
  - In SIGN, increment mag when guard & (sticky | mag[0]), then apply the sign.
  - e=126 takes the normal path with cnt=24.
  - e<126 still gives 0 with inexact set per the rule above.
  - inexact = guard | sticky.
- Undefined: truncation exactly as described in Behaviour.

Test Plan:
- 0x3F800000 (1.0), SHIFT_STEP=1 -> out_int=1, flags 0, out_valid 24 edges after accept. 0x4B7FFFFF -> 16777215, out_valid 1 edge after accept (k=0).
- 0xC0200000 (-2.5) -> 0xFFFFFFFE, inexact=1. With FP2INT_ROUND_EN -> 0xFFFFFFFE, and 0xC0600000 (-3.5) -> 0xFFFFFFFC.
- 0x4F000000 (2^31) -> 0x7FFFFFFF, overflow=1. 0xCF000000 -> 0x80000000, overflow=0. 0xFF800000 -> 0x80000000, overflow=1. Each gives out_valid 1 edge after accept.
- 0x7FC00000 -> out_int=0, nan_flag=1. 0x00000001 -> 0, inexact=1. 0x80000000 -> 0, all flags 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_int and flags stable, in_ready=0. Then out_ready=1 -> IDLE next edge, and a new operand is accepted the following cycle.
- Pull reset low during SHIFT of 0x3F800000 -> all outputs 0 immediately, in_ready=1. After release, 0x42F60000 (123.0) -> 123 with no stale flags.
